// File: rtl/player_move_grid_if.sv
// Keypad/collision inputs and sprite position outputs of the grid-aware player mover.
interface player_move_grid_if;
    logic               startOfFrame;
    logic               up_direction_key;
    logic               down_direction_key;
    logic               left_direction_key;
    logic               right_direction_key;
    logic               collision;
    logic [2:0]         HitEdgeCode;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [1:0]         facing;
    logic               moving;

    modport master (
        output startOfFrame, up_direction_key, down_direction_key,
               left_direction_key, right_direction_key, collision, HitEdgeCode,
        input  topLeftX, topLeftY, facing, moving
    );

    modport slave (
        input  startOfFrame, up_direction_key, down_direction_key,
               left_direction_key, right_direction_key, collision, HitEdgeCode,
        output topLeftX, topLeftY, facing, moving
    );
endinterface

// File: rtl/player_move_grid.sv
// Frame-stepped fixed-point player mover with wall revert and clamping.
// Define ALIGN_ASSIST_EN to pull the orthogonal axis onto the tile lattice while stepping.
module player_move_grid #(
    parameter int INITIAL_X = 272,
    parameter int INITIAL_Y = 176,
    parameter int FRAC_BITS = 12,
    parameter int SPEED_Q   = 8192,
    parameter int X_MIN     = 16,
    parameter int X_MAX     = 591,
    parameter int Y_MIN     = 48,
    parameter int Y_MAX     = 431
`ifdef ALIGN_ASSIST_EN
    ,
    parameter int TILE_SIZE     = 32,
    parameter int GRID_ORIGIN_X = 16,
    parameter int GRID_ORIGIN_Y = 48
`endif
) (
    input logic              clk,
    input logic              reset,
    player_move_grid_if.slave bus
);
    localparam int unsigned POS_W  = 32;
    localparam int unsigned OUT_W  = 11;
    localparam int unsigned FACE_W = 2;

    localparam logic signed [POS_W-1:0] INIT_XQ = POS_W'(INITIAL_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] INIT_YQ = POS_W'(INITIAL_Y << FRAC_BITS);
    localparam logic signed [POS_W-1:0] XMIN_Q  = POS_W'(X_MIN << FRAC_BITS);
    localparam logic signed [POS_W-1:0] XMAX_Q  = POS_W'(X_MAX << FRAC_BITS);
    localparam logic signed [POS_W-1:0] YMIN_Q  = POS_W'(Y_MIN << FRAC_BITS);
    localparam logic signed [POS_W-1:0] YMAX_Q  = POS_W'(Y_MAX << FRAC_BITS);
    localparam logic signed [POS_W-1:0] SPEED   = POS_W'(SPEED_Q);

    typedef enum logic [2:0] {
        IDLE_ST, MOVE_ST, START_OF_FRAME_ST, POSITION_CHANGE_ST, POSITION_LIMITS_ST
    } state_t;

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t                   state;
    dir_t                     dir_latched;
    dir_t                     key_dir;
    logic signed [POS_W-1:0]  pos_x, pos_y, prev_x, prev_y;
    logic signed [POS_W-1:0]  clamp_x, clamp_y;
    logic [4:0]               hit_reg;
    logic [FACE_W-1:0]        face_q;
    logic                     mov_q;

`ifdef ALIGN_ASSIST_EN
    localparam logic signed [POS_W-1:0] TILE_Q = POS_W'(TILE_SIZE << FRAC_BITS);
    localparam logic signed [POS_W-1:0] HALF_Q = POS_W'((TILE_SIZE << FRAC_BITS) / 2);
    localparam logic signed [POS_W-1:0] ORG_XQ = POS_W'(GRID_ORIGIN_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] ORG_YQ = POS_W'(GRID_ORIGIN_Y << FRAC_BITS);

    // Nudge toward the nearest tile line; an exact half tile rounds toward the lower line.
    function automatic logic signed [POS_W-1:0] align_step(
        input logic signed [POS_W-1:0] v,
        input logic signed [POS_W-1:0] org
    );
        logic signed [POS_W-1:0] rem;
        logic signed [POS_W-1:0] err;
        rem        = (v - org) & (TILE_Q - POS_W'(1));
        err        = TILE_Q - rem;
        align_step = v;
        if (rem != '0) begin
            if (rem <= HALF_Q)
                align_step = v - ((rem < SPEED) ? rem : SPEED);
            else
                align_step = v + ((err < SPEED) ? err : SPEED);
        end
    endfunction
`endif

    // Key priority: up > down > left > right.
    always_comb begin
        key_dir = DIR_NONE;
        if (bus.up_direction_key)         key_dir = DIR_UP;
        else if (bus.down_direction_key)  key_dir = DIR_DOWN;
        else if (bus.left_direction_key)  key_dir = DIR_LEFT;
        else if (bus.right_direction_key) key_dir = DIR_RIGHT;
    end

    always_comb begin
        clamp_x = pos_x;
        clamp_y = pos_y;
        if (pos_x < XMIN_Q)      clamp_x = XMIN_Q;
        else if (pos_x > XMAX_Q) clamp_x = XMAX_Q;
        if (pos_y < YMIN_Q)      clamp_y = YMIN_Q;
        else if (pos_y > YMAX_Q) clamp_y = YMAX_Q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE_ST;
            dir_latched  <= DIR_NONE;
            pos_x        <= INIT_XQ;
            pos_y        <= INIT_YQ;
            prev_x       <= INIT_XQ;
            prev_y       <= INIT_YQ;
            hit_reg      <= '0;
            face_q       <= '0;
            mov_q        <= 1'b0;
            bus.topLeftX <= OUT_W'(INITIAL_X);
            bus.topLeftY <= OUT_W'(INITIAL_Y);
            bus.facing   <= '0;
            bus.moving   <= 1'b0;
        end else begin
            case (state)
                IDLE_ST: begin
                    if (bus.startOfFrame) state <= MOVE_ST;
                end
                MOVE_ST: begin
                    if (bus.collision && (bus.HitEdgeCode <= 3'd4))
                        hit_reg[bus.HitEdgeCode] <= 1'b1;
                    if (bus.startOfFrame) begin
                        dir_latched <= key_dir;
                        state       <= START_OF_FRAME_ST;
                    end
                end
                START_OF_FRAME_ST: begin
                    // Edge codes 0..3 line up with the facing encoding; bit 4 is a corner hit.
                    if (mov_q && (hit_reg[4] || hit_reg[{1'b0, face_q}])) begin
                        pos_x <= prev_x;
                        pos_y <= prev_y;
                    end
                    hit_reg <= '0;
                    state   <= POSITION_CHANGE_ST;
                end
                POSITION_CHANGE_ST: begin
                    prev_x <= pos_x;
                    prev_y <= pos_y;
                    mov_q  <= 1'b1;
                    case (dir_latched)
                        DIR_UP: begin
                            pos_y  <= pos_y - SPEED;
                            face_q <= 2'd3;
`ifdef ALIGN_ASSIST_EN
                            pos_x  <= align_step(pos_x, ORG_XQ);
`endif
                        end
                        DIR_DOWN: begin
                            pos_y  <= pos_y + SPEED;
                            face_q <= 2'd0;
`ifdef ALIGN_ASSIST_EN
                            pos_x  <= align_step(pos_x, ORG_XQ);
`endif
                        end
                        DIR_LEFT: begin
                            pos_x  <= pos_x - SPEED;
                            face_q <= 2'd1;
`ifdef ALIGN_ASSIST_EN
                            pos_y  <= align_step(pos_y, ORG_YQ);
`endif
                        end
                        DIR_RIGHT: begin
                            pos_x  <= pos_x + SPEED;
                            face_q <= 2'd2;
`ifdef ALIGN_ASSIST_EN
                            pos_y  <= align_step(pos_y, ORG_YQ);
`endif
                        end
                        default: mov_q <= 1'b0;
                    endcase
                    state <= POSITION_LIMITS_ST;
                end
                POSITION_LIMITS_ST: begin
                    // All outputs publish together so a frame's update appears in one cycle.
                    pos_x        <= clamp_x;
                    pos_y        <= clamp_y;
                    bus.topLeftX <= OUT_W'(clamp_x >>> FRAC_BITS);
                    bus.topLeftY <= OUT_W'(clamp_y >>> FRAC_BITS);
                    bus.facing   <= face_q;
                    bus.moving   <= mov_q;
                    state        <= MOVE_ST;
                end
                default: state <= IDLE_ST;
            endcase
        end
    end
endmodule
